// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared fixed-point configuration for the math datapath blocks.
package fpga_cfg_pkg;

   localparam int FP_WIDTH     = 32;
   localparam int FP_QFRAC     = 16;
   localparam int FP_DIV_ROUND = 1;
   localparam int FP_DIV_SAT   = 1;

   // Largest positive two's-complement value of the given width, zero-extended to 64 bits
   function automatic logic [63:0] fx_max(input int width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   // Bit pattern of the most negative two's-complement value of the given width
   function automatic logic [63:0] fx_min(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/fx_div_step.sv
// fx_div_step: one radix-2 restoring division step (combinational).
module fx_div_step #(
   parameter int WIDTH = 33
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] divisor,
   input  logic             next_bit,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);
   logic [WIDTH-1:0] shifted;

   // Shift in the next dividend bit; a set bit shifted out means the value exceeds any divisor
   always_comb begin
      shifted  = {rem[WIDTH-2:0], next_bit};
      q_bit    = rem[WIDTH-1] || (shifted >= divisor);
      rem_next = q_bit ? (shifted - divisor) : shifted;
   end

endmodule

// File: rtl/fx_div_iter.sv
// fx_div_iter: signed Q(WIDTH-QFRAC).QFRAC divider, radix-2 restoring, one quotient bit per clock.
module fx_div_iter
   import fpga_cfg_pkg::*;
#(
   parameter int WIDTH = FP_WIDTH,
   parameter int QFRAC = FP_QFRAC,
   parameter int ROUND = FP_DIV_ROUND,
   parameter int SAT   = FP_DIV_SAT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic signed [WIDTH-1:0] numerator,
   input  logic signed [WIDTH-1:0] denominator,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic signed [WIDTH-1:0] result,
   output logic                    div_by_zero,
   output logic                    overflow
);
   // Quotient bits: integer + fraction, plus one guard bit when rounding
   localparam int N  = WIDTH + QFRAC + ROUND;
   localparam int MW = WIDTH + 1;
   localparam int CW = $clog2(N);
   localparam logic [63:0]      MAX64   = fx_max(WIDTH);
   localparam logic [63:0]      MIN64   = fx_min(WIDTH);
   localparam logic [WIDTH-1:0] MAX_POS = MAX64[WIDTH-1:0];
   localparam logic [WIDTH-1:0] MIN_NEG = MIN64[WIDTH-1:0];
   localparam logic [N-1:0]     LIM_POS = N'(MAX64);
   localparam logic [N-1:0]     LIM_NEG = N'(MIN64);

   if (QFRAC <= 0 || QFRAC >= WIDTH) begin : g_bad_qfrac
      $error("fx_div_iter: QFRAC must satisfy 0 < QFRAC < WIDTH");
   end
   if (ROUND != 0 && ROUND != 1) begin : g_bad_round
      $error("fx_div_iter: ROUND must be 0 or 1");
   end
   if (SAT != 0 && SAT != 1) begin : g_bad_sat
      $error("fx_div_iter: SAT must be 0 or 1");
   end
   if (WIDTH > 64) begin : g_bad_width
      $error("fx_div_iter: WIDTH above 64 is not supported");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic                    step_done;
   logic                    sign_p0;
   logic                    num_neg_p0;
   logic                    num_zero_p0;
   logic                    dz_p0;
   logic [MW-1:0]           den_p0;
   logic [MW-1:0]           rem_p0;
   logic [N-1:0]            dvd_p0;
   logic [N-1:0]            quo_p0;

   logic                    accept;
   logic signed [MW-1:0]    num_ext;
   logic signed [MW-1:0]    den_ext;
   logic [MW-1:0]           num_abs;
   logic [MW-1:0]           den_abs;
   logic [N-1:0]            dvd_init;
   logic [MW-1:0]           rem_nxt;
   logic                    q_bit;
   logic [N-1:0]            mag;
   logic                    ovf_c;
   logic [WIDTH-1:0]        res_wrap;
   logic [WIDTH-1:0]        fin_res;
   logic                    fin_ovf;

   assign ready_out = !rst && (state == IDLE || (state == DONE && ready_in));
   assign accept    = valid_in && ready_out;

   // Operand magnitudes one bit wider so the most negative input has a representable magnitude
   always_comb begin
      num_ext  = {numerator[WIDTH-1], numerator};
      den_ext  = {denominator[WIDTH-1], denominator};
      num_abs  = numerator[WIDTH-1] ? -num_ext : num_ext;
      den_abs  = denominator[WIDTH-1] ? -den_ext : den_ext;
      dvd_init = N'({num_abs, {(QFRAC + ROUND){1'b0}}});
   end

   fx_div_step #(.WIDTH(MW)) u_step (
      .rem      (rem_p0),
      .divisor  (den_p0),
      .next_bit (dvd_p0[N-1]),
      .rem_next (rem_nxt),
      .q_bit    (q_bit)
   );

   // Finalise: round the guard bit away from zero, detect range overflow, then saturate or wrap
   always_comb begin
      if (ROUND != 0) mag = (quo_p0 >> 1) + N'(quo_p0[0]);
      else            mag = quo_p0;
      ovf_c    = sign_p0 ? (mag > LIM_NEG) : (mag > LIM_POS);
      res_wrap = WIDTH'(sign_p0 ? (~mag + N'(1)) : mag);
      if (dz_p0)
         fin_res = num_zero_p0 ? '0 : (num_neg_p0 ? MIN_NEG : MAX_POS);
      else if (ovf_c && SAT != 0)
         fin_res = sign_p0 ? MIN_NEG : MAX_POS;
      else
         fin_res = res_wrap;
      fin_ovf = ovf_c && !dz_p0;
   end

   // --- stage p0: control FSM, operand flags and registered outputs ---
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         step_done   <= 1'b0;
         sign_p0     <= 1'b0;
         num_neg_p0  <= 1'b0;
         num_zero_p0 <= 1'b0;
         dz_p0       <= 1'b0;
         valid_out   <= 1'b0;
         result      <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (accept) begin
            sign_p0     <= numerator[WIDTH-1] ^ denominator[WIDTH-1];
            num_neg_p0  <= numerator[WIDTH-1];
            num_zero_p0 <= (numerator == '0);
            dz_p0       <= (denominator == '0);
            cnt         <= CW'(N - 1);
            step_done   <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (accept) state <= CALC;
            end
            CALC: begin
               if (step_done) begin
                  result      <= fin_res;
                  div_by_zero <= dz_p0;
                  overflow    <= fin_ovf;
                  valid_out   <= 1'b1;
                  state       <= DONE;
               end else if (cnt == '0) begin
                  step_done <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (ready_in) begin
                  valid_out <= 1'b0;
                  state     <= accept ? CALC : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // --- stage p0: iteration datapath (no reset; always reloaded on accept) ---
   always_ff @(posedge clk) begin
      if (accept) begin
         den_p0 <= den_abs;
         dvd_p0 <= dvd_init;
         rem_p0 <= '0;
         quo_p0 <= '0;
      end else if (state == CALC && !step_done) begin
         rem_p0 <= rem_nxt;
         dvd_p0 <= dvd_p0 << 1;
         quo_p0 <= {quo_p0[N-2:0], q_bit};
      end
   end

endmodule

// File: tb/tb_fx_div_iter.sv
// tb_fx_div_iter: directed table plus hand sequences for fx_div_iter (default, ROUND=0, SAT=0).
module tb_fx_div_iter;

   logic               clk;
   logic               rst;
   logic               valid_in;
   logic               ready_in;
   logic signed [31:0] numerator;
   logic signed [31:0] denominator;

   logic               ro_m, vo_m, dz_m, ov_m;
   logic signed [31:0] res_m;
   logic               ro_r, vo_r, dz_r, ov_r;
   logic signed [31:0] res_r;
   logic               ro_s, vo_s, dz_s, ov_s;
   logic signed [31:0] res_s;

   int checks;
   int failures;
   int lat_m, lat_r, lat_s;
   int stale;
   logic [31:0] cap_res_m, cap_res_r, cap_res_s;
   logic        cap_dz_m, cap_ov_m, cap_ov_s;

   typedef struct {
      logic [31:0] num;
      logic [31:0] den;
      logic [31:0] res;
      logic        dz;
      logic        ov;
      logic [31:0] res_r0;
      logic [31:0] res_s0;
   } vec_t;
   vec_t vecs [13];

   fx_div_iter dut_m (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ro_m),
      .numerator(numerator), .denominator(denominator),
      .valid_out(vo_m), .ready_in(ready_in), .result(res_m),
      .div_by_zero(dz_m), .overflow(ov_m)
   );

   fx_div_iter #(.ROUND(0)) dut_r (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ro_r),
      .numerator(numerator), .denominator(denominator),
      .valid_out(vo_r), .ready_in(ready_in), .result(res_r),
      .div_by_zero(dz_r), .overflow(ov_r)
   );

   fx_div_iter #(.SAT(0)) dut_s (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ro_s),
      .numerator(numerator), .denominator(denominator),
      .valid_out(vo_s), .ready_in(ready_in), .result(res_s),
      .div_by_zero(dz_s), .overflow(ov_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(ro_m && ro_r && ro_s && !vo_m && !vo_r && !vo_s) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL idle_wait actual=busy required=idle");
      end
   endtask

   task automatic run_op(input logic [31:0] num, input logic [31:0] den);
      wait_idle();
      numerator   = num;
      denominator = den;
      valid_in    = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      lat_m = -1;
      lat_r = -1;
      lat_s = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (vo_m && lat_m < 0) begin
            lat_m = c; cap_res_m = res_m; cap_dz_m = dz_m; cap_ov_m = ov_m;
         end
         if (vo_r && lat_r < 0) begin
            lat_r = c; cap_res_r = res_r;
         end
         if (vo_s && lat_s < 0) begin
            lat_s = c; cap_res_s = res_s; cap_ov_s = ov_s;
         end
         if (lat_m >= 0 && lat_r >= 0 && lat_s >= 0) break;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      // {num, den, result, div_by_zero, overflow, result ROUND=0, result SAT=0}
      vecs[0]  = '{32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0, 32'h00018000, 32'h00018000};
      vecs[1]  = '{32'h00020000, 32'h00030000, 32'h0000AAAB, 1'b0, 1'b0, 32'h0000AAAA, 32'h0000AAAB};
      vecs[2]  = '{32'hFFFE0000, 32'h00030000, 32'hFFFF5555, 1'b0, 1'b0, 32'hFFFF5556, 32'hFFFF5555};
      vecs[3]  = '{32'h00050000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF};
      vecs[4]  = '{32'hFFFB0000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 32'h80000000, 32'h80000000};
      vecs[5]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 32'h00000000};
      vecs[6]  = '{32'h7FFF0000, 32'h00000100, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h7FFFFFFF, 32'hFF000000};
      vecs[7]  = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 32'h80000000};
      vecs[8]  = '{32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000};
      vecs[9]  = '{32'hFFFE8000, 32'hFFFF8000, 32'h00030000, 1'b0, 1'b0, 32'h00030000, 32'h00030000};
      vecs[10] = '{32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0, 32'h00005555, 32'h00005555};
      vecs[11] = '{32'h00000001, 32'h00020000, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 32'h00000001};
      vecs[12] = '{32'hFFFFFFFF, 32'h00020000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 32'hFFFFFFFF};

      rst         = 1'b1;
      valid_in    = 1'b0;
      ready_in    = 1'b1;
      numerator   = '0;
      denominator = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid_out", 32'(vo_m), 32'd0);
      chk("rst_result", res_m, 32'd0);
      chk("rst_div_by_zero", 32'(dz_m), 32'd0);
      chk("rst_overflow", 32'(ov_m), 32'd0);
      chk("rst_ready_out", 32'(ro_m), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready_out", 32'(ro_m), 32'd1);

      // Table of directed vectors
      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].num, vecs[i].den);
         chk($sformatf("v%0d_result", i), cap_res_m, vecs[i].res);
         chk($sformatf("v%0d_div_by_zero", i), 32'(cap_dz_m), 32'(vecs[i].dz));
         chk($sformatf("v%0d_overflow", i), 32'(cap_ov_m), 32'(vecs[i].ov));
         chk($sformatf("v%0d_latency", i), 32'(lat_m), 32'd50);
         chk($sformatf("v%0d_r0_result", i), cap_res_r, vecs[i].res_r0);
         chk($sformatf("v%0d_r0_latency", i), 32'(lat_r), 32'd49);
         chk($sformatf("v%0d_s0_result", i), cap_res_s, vecs[i].res_s0);
         chk($sformatf("v%0d_s0_overflow", i), 32'(cap_ov_s), 32'(vecs[i].ov));
      end

      // Back-pressure: hold the result, then accept new operands on the release edge
      wait_idle();
      ready_in    = 1'b0;
      numerator   = 32'h00030000;
      denominator = 32'h00020000;
      valid_in    = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      lat_m = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (vo_m) begin
            lat_m = c;
            break;
         end
      end
      chk("bp_latency", 32'(lat_m), 32'd50);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_result", res_m, 32'h00018000);
         chk("bp_hold_valid_ready", {30'd0, vo_m, ro_m}, 32'd2);
         chk("bp_hold_flags", {30'd0, dz_m, ov_m}, 32'd0);
      end
      numerator   = 32'h00020000;
      denominator = 32'h00030000;
      valid_in    = 1'b1;
      ready_in    = 1'b1;
      #1;
      chk("bp_release_ready_out", 32'(ro_m), 32'd1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      chk("bp_accept_valid_drop", 32'(vo_m), 32'd0);
      lat_m = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (vo_m) begin
            lat_m = c;
            cap_res_m = res_m;
            break;
         end
      end
      chk("bp_next_latency", 32'(lat_m), 32'd50);
      chk("bp_next_result", cap_res_m, 32'h0000AAAB);

      // Reset in the middle of an iteration
      wait_idle();
      numerator   = 32'h7FFF0000;
      denominator = 32'h00000100;
      valid_in    = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid_out", 32'(vo_m), 32'd0);
      chk("mid_rst_result", res_m, 32'd0);
      chk("mid_rst_flags", {30'd0, dz_m, ov_m}, 32'd0);
      chk("mid_rst_ready_out", 32'(ro_m), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      stale = 0;
      for (int c = 0; c < 70; c++) begin
         @(posedge clk);
         #1;
         if (vo_m || vo_r || vo_s) stale++;
      end
      chk("mid_rst_no_stale_valid", 32'(stale), 32'd0);
      run_op(32'h00030000, 32'h00020000);
      chk("after_rst_result", cap_res_m, 32'h00018000);
      chk("after_rst_latency", 32'(lat_m), 32'd50);
      chk("after_rst_flags", {30'd0, cap_dz_m, cap_ov_m}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fx_div_iter.md
# fx_div_iter

Parametrised, IP-free signed Qm.n fixed-point divider using a radix-2 restoring iteration, one quotient bit per clock. It replaces the vendor-core divider in the LSM regression datapath wherever WIDTH/QFRAC differ from 32/16, or where explicit divide-by-zero, overflow, rounding and saturation behaviour is needed. It uses the same valid/ready handshake as the rest of the math blocks.

## Interface
- WIDTH, default fpga_cfg_pkg::FP_WIDTH (32): operand and result width.
- QFRAC, default fpga_cfg_pkg::FP_QFRAC (16): fractional bits. Must satisfy 0 < QFRAC < WIDTH.
- ROUND, default 1: 1 rounds half away from zero; 0 truncates toward zero.
- SAT, default 1: 1 clamps on overflow; 0 wraps to the low WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  operand pair valid.
- ready_out  out  1  block accepts operands.
- numerator  in  WIDTH signed  Q(WIDTH-QFRAC).QFRAC dividend.
- denominator  in  WIDTH signed  divisor, same format.
- valid_out  out  1  result valid.
- ready_in  in  1  downstream accepts result.
- result  out  WIDTH signed  quotient, same format.
- div_by_zero  out  1  denominator was 0; qualified by valid_out.
- overflow  out  1  quotient out of range; qualified by valid_out.

## Operation
- The state machine has three states: IDLE, CALC and DONE. Reset forces IDLE.
- **Accept.** A transfer occurs when valid_in && ready_out. On accept the block registers:
  - the sign, as numerator[MSB] XOR denominator[MSB];
  - the magnitudes |numerator| and |denominator| as unsigned WIDTH+1 bits, so the most negative value is handled;
  - the dividend magnitude shifted left by QFRAC;
  - an iteration counter loaded with N-1, where N = WIDTH+QFRAC+ROUND;
  - a zero-divisor flag.
  Then the state moves to CALC.
- **CALC.** Each cycle performs one restoring step:
  - remainder = (remainder<<1) | next dividend bit;
  - if remainder ≥ |den|, subtract |den| and shift in a quotient bit of 1; otherwise shift in 0.
  - When the counter reaches 0, the finalise stage runs and the state moves to DONE.
- **Finalise** (registered on the CALC→DONE edge):
  - If ROUND=1, the magnitude is (q>>1) + q[0].
  - Overflow is set when the magnitude exceeds 2^(WIDTH-1)-1 for a positive sign, or 2^(WIDTH-1) for a negative sign.
  - If SAT=1 and overflow: result = 0x7FF..F for a positive sign, 0x800..0 for a negative sign. If SAT=0: the low WIDTH bits of the signed value.
  - Otherwise result is the magnitude negated when the sign is 1.
- **Divide by zero.** The iterations still run, so latency is unchanged, but their quotient is ignored:
  - result = max positive if numerator > 0, most negative if numerator < 0, and 0 if numerator = 0;
  - div_by_zero = 1 and overflow = 0. This holds regardless of SAT.
- **DONE.** valid_out = 1. result and both flags hold stable until ready_in.
  - If ready_in and no new accept: go to IDLE.
  - If ready_in and valid_in: accept the new operands and go to CALC.
- **ready_out** = !rst && (state==IDLE || (state==DONE && ready_in)).

## Timing
- Reset values: valid_out=0, result=0, div_by_zero=0, overflow=0. ready_out=0 while rst is asserted, and 1 in the first cycle after release.
- Latency: with the accept on edge E0, valid_out rises after edge E(N+1), i.e. N+1 cycles. The default is N=49, giving 50 cycles.
- Initiation interval with ready_in held at 1: N+2 cycles.
- Outputs change only on the finalise edge or on reset. They never change while valid_out && !ready_in.
- Reset asserted mid-CALC or in DONE aborts the operation. The result is discarded, and no valid_out follows reset release.
- ready_out is combinational from state, rst and ready_in. There is no path from valid_in to ready_out.

## Structure
- fpga_cfg_pkg gains two constants, FP_DIV_ROUND and FP_DIV_SAT, used as the parameter defaults.
- fpga_cfg_pkg also gains the function fx_max(WIDTH) / fx_min(WIDTH) for the saturation constants.
- The state enum stays local to the module.
- One sub-module, fx_div_step, is purely combinational. Its inputs are the remainder, the divisor and the next bit; its outputs are the new remainder and the quotient bit. It is instantiated once.
- Elaboration assertions check QFRAC range, and that ROUND and SAT are 0 or 1.

## Test plan
All cases use defaults (32/16, ROUND=1, SAT=1) unless stated.
- **Basic divide.** num=0x00030000, den=0x00020000 -> result=0x00018000, no flags, valid_out exactly 50 cycles after accept.
- **Rounding.** num=0x00020000, den=0x00030000 -> 0x0000AAAB. With ROUND=0 (latency 49) -> 0x0000AAAA. num=0xFFFE0000 with the same den -> 0xFFFF5555.
- **Divide by zero.** den=0 with num=0x00050000 -> 0x7FFFFFFF, div_by_zero=1. With num=0xFFFB0000 -> 0x80000000. With num=0 -> 0. Latency is unchanged in every case.
- **Overflow.**
  - num=0x7FFF0000, den=0x00000100 -> 0x7FFFFFFF, overflow=1. With SAT=0 the result is the wrapped low 32 bits.
  - num=0x80000000, den=0x00010000 -> 0x80000000 with no overflow.
  - num=0x80000000, den=0xFFFF0000 -> 0x7FFFFFFF with overflow=1.
- **Back-pressure.** Hold ready_in=0 for 20 cycles after valid_out: result and flags stay stable and ready_out stays 0. Then raise ready_in together with a new valid_in: the new operands are accepted on that same edge, and their result arrives 50 cycles later.
- **Reset mid-operation.** Assert rst at cycle 25 of CALC: all outputs go to 0 immediately. After release, no stale valid_out appears, and a new divide completes correctly.
